// File: rtl/parity_pkg.sv
// Shared constants and types for the parity byte feeder: byte width, dispatch
// FSM encoding and the parity unit's worst-case run length.
package parity_pkg;
  localparam int BYTE_W              = 8;
  localparam int PARITY_WORST_CYCLES = 20;
  // Margin over the worst case so completion is never sampled mid-run.
  localparam int GUARD_DEFAULT       = PARITY_WORST_CYCLES + 4;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LAUNCH    = 3'd1;
  localparam logic [2:0] S_GUARD     = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_CAPTURE   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE      = S_IDLE,
    ST_LAUNCH    = S_LAUNCH,
    ST_GUARD     = S_GUARD,
    ST_WAIT_DONE = S_WAIT_DONE,
    ST_CAPTURE   = S_CAPTURE
  } state_t;

  typedef struct packed {
    logic              odd;
    logic [BYTE_W-1:0] data;
  } result_t;
endpackage

// File: rtl/parity_byte_fifo.sv
// Circular-buffer FIFO; a push while full is accepted only if a pop frees the
// slot in the same cycle.
module parity_byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             wr_en, rd_en;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign rd_en    = pop && !empty;
  assign wr_en    = push && (!full || rd_en);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/parity_byte_feeder.sv
// Deserialises an LSB-first bit stream into bytes, buffers them, and feeds
// them one at a time to the parity unit, re-publishing each verdict.
module parity_byte_feeder
  import parity_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int GUARD_CYCLES = GUARD_DEFAULT,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ser_in,
  input  logic              ser_valid,
  output logic [BYTE_W-1:0] par_data,
  output logic              par_start,
  input  logic              par_busy,
  input  logic              par_even,
  input  logic              par_odd,
  output logic              res_valid,
  output logic [BYTE_W-1:0] res_byte,
  output logic              res_odd,
  output logic [CW-1:0]     fifo_count,
  output logic              overflow
);
  logic [2:0]        bit_cnt;
  logic [6:0]        shreg;
  logic              byte_done;
  logic [BYTE_W-1:0] byte_data, head;
  logic              pop, full, empty;
  state_t            state, state_nxt;
  logic [7:0]        guard_cnt;
  result_t           res;

  // Earlier bits shift down so that on the 8th bit shreg holds bits 0..6.
  assign byte_done = ser_valid && (bit_cnt == 3'd7);
  assign byte_data = {ser_in, shreg};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt  <= '0;
      shreg    <= '0;
      overflow <= 1'b0;
    end else begin
      if (ser_valid) begin
        bit_cnt <= bit_cnt + 3'd1;
        shreg   <= {ser_in, shreg[6:1]};
      end
      if (byte_done && full && !pop) overflow <= 1'b1;
    end
  end

  parity_byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(BYTE_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (byte_done),
    .push_data (byte_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    par_start = 1'b0;
    res_valid = 1'b0;
    case (state)
      ST_IDLE: if (!empty) begin
        pop       = 1'b1;
        state_nxt = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        par_start = 1'b1;
        state_nxt = ST_GUARD;
      end
      ST_GUARD:     if (guard_cnt == '0) state_nxt = ST_WAIT_DONE;
      // Conflicting or absent verdicts mean the unit has not settled.
      ST_WAIT_DONE: if (!par_busy && (par_even ^ par_odd)) state_nxt = ST_CAPTURE;
      ST_CAPTURE: begin
        res_valid = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      guard_cnt <= '0;
      par_data  <= '0;
      res       <= '0;
    end else begin
      state <= state_nxt;
      if (pop) par_data <= head;
      if (state == ST_LAUNCH) guard_cnt <= 8'(GUARD_CYCLES - 1);
      else if (state == ST_GUARD && guard_cnt != '0) guard_cnt <= guard_cnt - 8'd1;
      if (state == ST_WAIT_DONE && state_nxt == ST_CAPTURE) begin
        res.odd  <= par_odd;
        res.data <= par_data;
      end
    end
  end

  assign res_byte = res.data;
  assign res_odd  = res.odd;
endmodule
